bit_serial_adder: RTL

- Multi-bit adder that reuses a single 1-bit full-adder slice, one bit per clock, LSB first.
- Sits directly upstream of the existing full_adder cell, which it instantiates once. It supplies the slice with x, y and carry_in, then registers sum and carry_out back into its own datapath.
- Trades latency (WIDTH cycles) for area. Used by lab datapaths that need wide adds without a ripple chain.

---
 rtl/bit_serial_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one shared full-adder slice resolves one bit per clock, LSB first.
// {carry_out, sum} = a + b + carry_in after WIDTH SHIFT cycles; both hold until the next completion.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = x ^ y ^ carry_in;
  assign carry_out = (x & y) | (carry_in & (x ^ y));
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one bit per edge through the slice, LSB first
// DONE  | single-cycle pulse, sum/carry_out freshly updated
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sh_a, sh_b, partial;
  logic [CW-1:0]    count;
  logic             c_reg;
  logic             slice_sum, slice_carry;
  logic             last_bit;

  full_adder u_slice (
    .x         (sh_a[0]),
    .y         (sh_b[0]),
    .carry_in  (c_reg),
    .sum       (slice_sum),
    .carry_out (slice_carry)
  );

  assign last_bit = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Result bits enter at the MSB of partial and shift right, so after WIDTH
  // edges bit 0 sits at the LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a      <= '0;
      sh_b      <= '0;
      partial   <= '0;
      count     <= '0;
      c_reg     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a    <= a;
            sh_b    <= b;
            c_reg   <= carry_in;
            count   <= '0;
            partial <= '0;
          end
        end
        SHIFT: begin
          sh_a    <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b    <= {1'b0, sh_b[WIDTH-1:1]};
          c_reg   <= slice_carry;
          partial <= {slice_sum, partial[WIDTH-1:1]};
          count   <= count + CW'(1);
          if (last_bit) begin
            sum       <= {slice_sum, partial[WIDTH-1:1]};
            carry_out <= slice_carry;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
